// File: rtl/cover_toggle_drain_arbiter.sv
// rtl/cover_toggle_drain_arbiter.sv - serialises sticky toggle-coverage hits onto one valid/ready report channel
// Round-robin grant over pending bits; optional dedup until clear_seen.
module cover_toggle_drain_arbiter #(
  parameter int WIDTH       = 34,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32,
  parameter int DEDUP       = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear_seen,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [IDX_W-1:0] report_index,
  output logic             busy,
  output logic [31:0]      hit_count
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pending, seen, new_hits, grant_clear;
  logic [PTR_W-1:0] rr_ptr, grant_idx;
  logic             grant_found, load, handshake;
  int               search_idx;

  assign new_hits = (DEDUP != 0) ? (valid & ~seen) : valid;

  // First pending bit at or after rr_ptr, wrapping past WIDTH-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = 0;
    for (int off = 0; off < WIDTH; off++) begin
      search_idx = int'(rr_ptr) + off;
      if (search_idx >= WIDTH) search_idx = search_idx - WIDTH;
      if (!grant_found && pending[search_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx[PTR_W-1:0];
      end
    end
  end

  assign handshake = (state == PRESENT) && report_ready;
  assign load      = grant_found && ((state == IDLE) || handshake);

  always_comb begin
    grant_clear            = '0;
    grant_clear[grant_idx] = load;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = PRESENT;
      PRESENT: if (handshake && !grant_found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    report_valid = (state == PRESENT);
    busy         = (|pending) | report_valid;
  end

  // New hits are OR-ed in after the grant clear, so a same-cycle hit re-arms the bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '0;
      seen         <= '0;
      rr_ptr       <= '0;
      hit_count    <= '0;
      report_index <= '0;
    end else begin
      pending <= (pending & ~grant_clear) | new_hits;
      if (DEDUP != 0) seen <= clear_seen ? '0 : (seen | new_hits);
      else            seen <= '0;
      if (load) begin
        report_index <= IDX_W'(COVER_INDEX) + IDX_W'(grant_idx);
        rr_ptr       <= (grant_idx == PTR_W'(WIDTH - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      if (handshake && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_cover_toggle_drain_arbiter.sv
// tb/tb_cover_toggle_drain_arbiter.sv - directed self-checking bench for cover_toggle_drain_arbiter
module tb_cover_toggle_drain_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [33:0] valid, valid0;
  logic        clear_seen, clear_seen0;
  logic        report_ready, ready0;
  logic        report_valid, rv0;
  logic [31:0] report_index, idx0;
  logic        busy, busy0;
  logic [31:0] hit_count, hc0;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  cover_toggle_drain_arbiter #(.WIDTH(34), .COVER_INDEX(100), .IDX_W(32), .DEDUP(1)) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear_seen(clear_seen),
    .report_valid(report_valid), .report_ready(report_ready), .report_index(report_index),
    .busy(busy), .hit_count(hit_count)
  );

  cover_toggle_drain_arbiter #(.WIDTH(34), .COVER_INDEX(100), .IDX_W(32), .DEDUP(0)) dut0 (
    .clock(clock), .reset(reset), .valid(valid0), .clear_seen(clear_seen0),
    .report_valid(rv0), .report_ready(ready0), .report_index(idx0),
    .busy(busy0), .hit_count(hc0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [33:0] bitv(input int b);
    logic [33:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    reset = 1'b1; valid = '0; valid0 = '0; clear_seen = 1'b0; clear_seen0 = 1'b0;
    report_ready = 1'b1; ready0 = 1'b1;
    step(); step();
    check("rst_valid", report_valid, 0);
    check("rst_index", report_index, 0);
    check("rst_busy", busy, 0);
    check("rst_count", hit_count, 0);
    reset = 1'b0;

    // single hit, 2-cycle latency, one-cycle report
    valid = bitv(5); step(); valid = '0;
    check("t1_nolat_valid", report_valid, 0);
    check("t1_busy_pend", busy, 1);
    step();
    check("t1_valid", report_valid, 1);
    check("t1_index", report_index, 105);
    step();
    check("t1_done_valid", report_valid, 0);
    check("t1_count", hit_count, 1);
    check("t1_idle_busy", busy, 0);

    // three bits incl. the top two, back-to-back, pointer wraps
    reset = 1'b1; step(); reset = 1'b0;
    valid = 34'h3_0000_0001; step(); valid = '0;
    step(); check("t2_first", report_index, 100); check("t2_first_v", report_valid, 1);
    step(); check("t2_second", report_index, 132); check("t2_second_v", report_valid, 1);
    step(); check("t2_third", report_index, 133); check("t2_third_v", report_valid, 1);
    step(); check("t2_end_v", report_valid, 0); check("t2_count", hit_count, 3);
    valid = bitv(1) | bitv(31); step(); valid = '0;
    step(); check("t2_wrap_a", report_index, 101);
    step(); check("t2_wrap_b", report_index, 131);
    step(); check("t2_wrap_end", report_valid, 0);

    // backpressure with a repeat hit during the stall
    report_ready = 1'b0;
    valid = bitv(7); step(); valid = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_v", report_valid, 1);
      check("t3_hold_idx", report_index, 107);
      valid = (i == 4) ? bitv(7) : '0;
      step();
    end
    valid = '0;
    report_ready = 1'b1; step();
    check("t3_after_v", report_valid, 0);
    check("t3_after_busy", busy, 0);
    check("t3_count", hit_count, 6);
    step();
    check("t3_no_dup", report_valid, 0);

    // dedup until clear_seen
    reset = 1'b1; step(); reset = 1'b0;
    valid = bitv(3); step(); valid = '0;
    step(); check("t4_first", report_index, 103); check("t4_first_v", report_valid, 1);
    step(); check("t4_first_end", report_valid, 0);
    repeat (18) step();
    valid = bitv(3); step(); valid = '0;
    step(); check("t4_dedup_v", report_valid, 0);
    step(); check("t4_dedup_busy", busy, 0);
    clear_seen = 1'b1; step(); clear_seen = 1'b0;
    valid = bitv(3); step(); valid = '0;
    step(); check("t4_again_v", report_valid, 1); check("t4_again_idx", report_index, 103);
    step(); check("t4_count", hit_count, 2); check("t4_end_v", report_valid, 0);

    // no-dedup instance: held hits alternate fairly
    valid0 = bitv(1) | bitv(2);
    step(); step();
    for (int i = 0; i < 6; i++) begin
      check("t5_rr_v", rv0, 1);
      check("t5_rr_idx", idx0, 101 + (i % 2));
      step();
    end
    valid0 = '0;

    // reset while presenting with three pending; valid ignored under reset
    report_ready = 1'b0;
    valid = bitv(25) | bitv(26) | bitv(27) | bitv(28); step(); valid = '0;
    step();
    check("t6_pre_v", report_valid, 1);
    check("t6_pre_idx", report_index, 125);
    reset = 1'b1; valid = bitv(9); step(); reset = 1'b0; valid = '0;
    check("t6_rst_v", report_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", hit_count, 0);
    step();
    check("t6_ignored_busy", busy, 0);
    report_ready = 1'b1;
    valid = bitv(5) | bitv(30); step(); valid = '0;
    step(); check("t6_ptr0_a", report_index, 105);
    step(); check("t6_ptr0_b", report_index, 130);
    step(); check("t6_end_v", report_valid, 0); check("t6_count", hit_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/cover_toggle_drain_arbiter.md
Name: cover_toggle_drain_arbiter

Overview:
Collects per-cycle toggle-coverage hits from a WIDTH-bit valid vector and serialises them onto one valid/ready report channel, one cover index per handshake. It sits between a toggle-coverage point group and a shared coverage sink (DPI bridge or on-chip coverage buffer), so many coverage bits share one reporting resource. Hits are held in sticky pending bits, so none are lost under backpressure. Pending bits are granted round-robin.

Parameters:
WIDTH, 34, number of toggle points (valid bits) handled by this instance
COVER_INDEX, 0, global cover index of bit 0; bit i reports COVER_INDEX+i
IDX_W, 32, width of report_index
DEDUP, 1, 1 = report each bit at most once until clear_seen; 0 = report every hit (coalesced while pending)

Ports:
clock  input  1  single clock, all state on posedge
reset  input  1  synchronous, active-high reset
valid  input  WIDTH  toggle hit vector, bit i = point i hit this cycle
clear_seen  input  1  1-cycle pulse, clears the seen register (DEDUP=1 only)
report_valid  output  1  report_index is valid
report_ready  input  1  sink accepts the report this cycle
report_index  output  IDX_W  COVER_INDEX + granted bit number
busy  output  1  pending != 0 or report_valid
hit_count  output  32  number of completed handshakes, saturates at 0xFFFF_FFFF

Behaviour:
- Reset (synchronous, reset=1 at posedge) clears pending, seen, rr_ptr and hit_count. It sets report_valid=0, report_index=0 and the FSM to IDLE.
- A reset at any point, including mid-PRESENT, drops all queued and presented reports. valid is ignored while reset=1.
- Capture on each posedge without reset:
  - new = valid & ~seen when DEDUP=1, else new = valid.
  - pending <= (pending & ~grant_clear) | new.
  - With DEDUP=1: seen <= seen | new. clear_seen takes priority and sets seen <= 0 in that cycle, while that cycle's new bits still enter pending.
- Grant selection is combinational over pending:
  - Pick the first set bit at index >= rr_ptr, wrapping from WIDTH-1 to 0.
  - After a grant of bit g: rr_ptr <= (g == WIDTH-1) ? 0 : g+1.
- FSM states:
  - IDLE:
    - If pending != 0: load report_index <= COVER_INDEX+g, clear pending[g], set report_valid=1, go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT:
    - report_valid=1. report_index is held stable until report_ready=1.
    - On a handshake (report_valid & report_ready): hit_count increments (saturating).
    - If the handshake occurs and pending != 0, load the next grant in the same cycle and stay in PRESENT. This gives back-to-back throughput of 1 report per cycle.
    - If the handshake occurs and pending == 0, go to IDLE with report_valid=0.
- Latency: a hit sampled at posedge N sets pending at N. The earliest report_valid is after posedge N+1, i.e. 2 cycles from valid high to report_valid when idle.
- Simultaneous events:
  - A new hit on bit g in the same cycle that g is granted (cleared) is set again in pending; setting wins over clearing.
  - With DEDUP=1 that case cannot occur, because seen[g] is already set.
- Hits on a bit already pending coalesce into one report.
- No overflow condition exists: pending is bounded at WIDTH bits.
- report_index arithmetic is COVER_INDEX+g computed in IDX_W bits, truncating modulo 2^IDX_W.
- busy is combinational: busy = (pending != 0) | report_valid.

Test Plan:
- WIDTH=34, COVER_INDEX=100, DEDUP=1, report_ready=1. Pulse valid=bit5 for 1 cycle → report_valid high 2 cycles later with report_index=105 for exactly 1 cycle; hit_count=1; busy=0 afterwards.
- Pulse valid=0x3_0000_0001 (bits 0, 32, 33) in one cycle, report_ready=1 → reports 100, 132, 133 on consecutive cycles; rr_ptr wraps to 0.
- Backpressure: valid=bit7, report_ready=0 for 10 cycles → report_index holds at 107 with report_valid=1 throughout. Pulse bit7 again during the stall → with DEDUP=1, only one report after ready rises.
- DEDUP: hit bit3 twice 20 cycles apart → one report (103). Pulse clear_seen, then hit bit3 → second report 103; hit_count=2.
- DEDUP=0, round-robin fairness: hold valid=bits 1 and 2 every cycle with report_ready=1 → reports alternate 101, 102, 101, 102 …
- Reset while PRESENT with 3 bits pending: assert reset for 1 cycle → report_valid=0, busy=0, hit_count=0 on the next cycle. Later hits report from rr_ptr=0.
